// File: rtl/imdct_axil_master.sv
// imdct_axil_master: AXI4-Lite initiator for the IMDCT accelerator register port.
// Latency: 3 cycles from cmd handshake to rsp_valid with an always-ready slave; one transaction at a time.
// Backpressure: cmd_ready is high only in IDLE; rsp is held stable until rsp_ready; AXI valids are held until ready.
//
// Ports:
//   clock, reset_n               : clock (rising edge), asynchronous active-low reset
//   cmd_*                        : command stream (write flag, byte address, data, strobes)
//   rsp_*                        : response stream (write echo, read data, BRESP/RRESP)
//   m_axi_aw*/w*/b*/ar*/r*       : AXI4-Lite master channels; every output is driven from a flop
//   timeout_err                  : sticky watchdog flag, present only when IMDCT_AXIL_TIMEOUT_EN is defined
//
// Optional feature macro: IMDCT_AXIL_TIMEOUT_EN adds a 16-bit wait-state watchdog counter and the
// timeout_err port. The watchdog only reports; the FSM keeps waiting so the AXI protocol is never broken.
module imdct_axil_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clock,
  input  logic                            reset_n,
  // command stream
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response stream
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  // AXI4-Lite write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  // AXI4-Lite write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  // AXI4-Lite read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  // AXI4-Lite read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
`ifdef IMDCT_AXIL_TIMEOUT_EN
  ,
  output logic                            timeout_err
`endif
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  // Elaboration-time parameter sanity: only a 32-bit bus is implemented, and the
  // watchdog limit must fit the 16-bit counter.
  if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("imdct_axil_master: only C_M_AXI_DATA_WIDTH=32 is supported");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("imdct_axil_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                          state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic                            write_q, write_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  assign cmd_hs = cmd_valid && cmd_ready_q;
  assign aw_hs  = awvalid_q && m_axi_awready;
  assign w_hs   = wvalid_q && m_axi_wready;
  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      WR: begin
        // AW and W retire independently; each valid drops only on its own handshake.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          state_d   = WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      WR_RESP: begin
        // bready_q is high throughout this state, so bvalid alone completes B.
        if (m_axi_bvalid) begin
          resp_d      = m_axi_bresp;
          rdata_d     = '0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi_rvalid) begin
          rdata_d     = m_axi_rdata;
          resp_d      = m_axi_rresp;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered ready: high exactly in the cycles the FSM will sit in IDLE.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

`ifdef IMDCT_AXIL_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] to_cnt_q, to_cnt_d;
  logic        to_err_q, to_err_d;
  logic        in_wait;
  logic        enter_wait;

  always_comb begin
    to_cnt_d   = to_cnt_q;
    to_err_d   = to_err_q;
    in_wait    = (state_q == WR) || (state_q == WR_RESP) ||
                 (state_q == RD_ADDR) || (state_q == RD_DATA);
    enter_wait = (state_d != state_q) &&
                 ((state_d == WR) || (state_d == WR_RESP) ||
                  (state_d == RD_ADDR) || (state_d == RD_DATA));
    // Each wait phase is timed separately; the counter saturates rather than wraps.
    if (enter_wait) begin
      to_cnt_d = '0;
    end else if (in_wait && (to_cnt_q != 16'hFFFF)) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
    if (in_wait && (to_cnt_d >= TO_LIMIT)) begin
      to_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule
